// File: rtl/exe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// exe_fwd_ctrl
//
// Forwarding and hazard controller for the execute stage of a 5-stage ARM
// pipeline. It shadows the instructions in EXE, MEM and WB in a small
// scoreboard. From that scoreboard it produces:
//   - registered operand-source selects for the two EXE operand muxes, and
//   - the freeze/bubble controls that sequence IF/ID/EXE around load-use
//     hazards, taken branches and slow memory.
//
// Build option:
//   EXE_FWD_EN  defined   -> forwarding from the EX/MEM slots. Only a load
//                            that is immediately followed by its consumer
//                            stalls (one bubble).
//               undefined -> sel_src1/2 are tied to 0. Any dependency on the
//                            EX or MEM slot stalls until the producer leaves
//                            MEM (up to two bubbles).
//
// Parameters:
//   MEM_TIMEOUT   consecutive mem_ready-low cycles before mem_timeout sets.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            synchronous, active-low reset
//   id_valid       ID holds a real instruction
//   id_src1        Rn index of the ID instruction
//   id_src2        Rm/Rd index of the ID instruction
//   id_two_src     id_src2 is a real read (register operand or STR data)
//   id_dst         destination register of the ID instruction
//   id_wb_en       ID instruction writes the register file
//   id_mem_r_en    ID instruction is a load
//   branch_taken   EXE resolved a taken branch; flush IF/ID
//   mem_ready      memory stage can complete this cycle
//   sel_src1/2     EXE operand select: 0 reg file, 1 MEM-stage ALU value,
//                  2 WB value (registered)
//   hazard_freeze  hold PC and IF/ID (combinational)
//   bubble         ID/EXE register loads a NOP this cycle (combinational)
//   pipe_freeze    hold every pipeline register; equals !mem_ready
//   mem_timeout    sticky memory-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module exe_fwd_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic [3:0] id_dst,
  input  logic       id_wb_en,
  input  logic       id_mem_r_en,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [1:0] sel_src1,
  output logic [1:0] sel_src2,
  output logic       hazard_freeze,
  output logic       bubble,
  output logic       pipe_freeze,
  output logic       mem_timeout
);

  localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [1:0]       SEL_RF  = 2'd0;

  typedef struct packed {
    logic       valid;
    logic [3:0] dst;
    logic       wb_en;
    logic       mem_r_en;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_MWAIT
  } state_e;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  state_e           state_q, state_d;
  state_e           prev_q, prev_d;     // state to resume after MWAIT
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic stall_req;

  function automatic logic slot_hit(input slot_t s, input logic [3:0] src);
    return s.valid && s.wb_en && (s.dst == src);
  endfunction

  // ---------------------------------------------------------------------------
  // Dependency detection: ID sources against the EX and MEM producers.
  // WB producers need no tracking here: the register file writes on the
  // falling edge, so its read already returns the WB value.
  // ---------------------------------------------------------------------------
  assign hit1_ex  = id_valid && slot_hit(ex_q, id_src1);
  assign hit2_ex  = id_valid && id_two_src && slot_hit(ex_q, id_src2);
  assign hit1_mem = id_valid && slot_hit(mem_q, id_src1);
  assign hit2_mem = id_valid && id_two_src && slot_hit(mem_q, id_src2);

`ifdef EXE_FWD_EN
  // Only a load in EX cannot be forwarded yet: its data arrives from MEM.
  assign stall_req = (hit1_ex || hit2_ex) && ex_q.mem_r_en;
`else
  assign stall_req = hit1_ex || hit2_ex || hit1_mem || hit2_mem;
`endif

  // A memory wait overrides everything. A taken branch flushes the consumer,
  // so it cancels any stall that the consumer would have caused.
  assign pipe_freeze   = !mem_ready;
  assign hazard_freeze = !pipe_freeze && !branch_taken && stall_req;
  assign bubble        = !pipe_freeze && (branch_taken || stall_req);
  assign mem_timeout   = timeout_q;

  // ---------------------------------------------------------------------------
  // Scoreboard shift, FSM and timeout counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d   = state_q;
    prev_d    = prev_q;
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    cnt_d     = '0;
    timeout_d = timeout_q;

    if (pipe_freeze) begin
      state_d = ST_MWAIT;
      if (state_q != ST_MWAIT) begin
        prev_d = state_q;
      end
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_valid && !bubble) begin
        ex_d = '{valid: 1'b1, dst: id_dst, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
      end else begin
        ex_d = '0;
      end

      if (branch_taken) begin
        state_d = ST_RUN;
      end else if (stall_req) begin
        state_d = ST_LDSTALL;
      end else if (state_q == ST_MWAIT) begin
        state_d = prev_q;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled on the clock edge only; rst is not in the
    // sensitivity list.
    if (!rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= ST_RUN;
      prev_q    <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      state_q   <= state_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // The WB slot completes the shadow of the pipeline for debug visibility.
  // No decision reads it, because the register file read-through covers WB.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  // ---------------------------------------------------------------------------
  // Operand selects: computed while the consumer sits in ID, and registered so
  // that they are stable for its whole EXE cycle.
  // ---------------------------------------------------------------------------
`ifdef EXE_FWD_EN
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  logic [1:0] sel1_q, sel1_d;
  logic [1:0] sel2_q, sel2_d;

  always_comb begin
    sel1_d = sel1_q;
    sel2_d = sel2_q;
    if (!pipe_freeze) begin
      if (branch_taken) begin
        sel1_d = SEL_RF;
        sel2_d = SEL_RF;
      end else begin
        // The EX slot holds the youngest producer, so it wins over MEM.
        sel1_d = hit1_ex ? SEL_ALU : (hit1_mem ? SEL_WB : SEL_RF);
        sel2_d = hit2_ex ? SEL_ALU : (hit2_mem ? SEL_WB : SEL_RF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel1_q <= SEL_RF;
      sel2_q <= SEL_RF;
    end else begin
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end

  assign sel_src1 = sel1_q;
  assign sel_src2 = sel2_q;
`else
  assign sel_src1 = SEL_RF;
  assign sel_src2 = SEL_RF;
`endif

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for exe_fwd_ctrl.
// The stimulus process drives one cycle at a time, shortly after each rising
// edge. For each cycle it checks, it pushes the expected outputs into a queue.
// A monitor process samples the DUT on the falling edge and pops and compares
// one entry per cycle. Expected values follow whichever EXE_FWD_EN build is
// compiled.
// -----------------------------------------------------------------------------
module tb_exe_fwd_ctrl;

  localparam int MEM_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic [3:0] id_dst;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       branch_taken;
  logic       mem_ready;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic       hazard_freeze;
  logic       bubble;
  logic       pipe_freeze;
  logic       mem_timeout;

  always #5 clk = ~clk;

  exe_fwd_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_two_src    (id_two_src),
    .id_dst        (id_dst),
    .id_wb_en      (id_wb_en),
    .id_mem_r_en   (id_mem_r_en),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .sel_src1      (sel_src1),
    .sel_src2      (sel_src2),
    .hazard_freeze (hazard_freeze),
    .bubble        (bubble),
    .pipe_freeze   (pipe_freeze),
    .mem_timeout   (mem_timeout)
  );

  typedef struct {
    string      tag;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       hf;
    logic       bub;
    logic       pf;
    logic       to;
    bit         chk_sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t       e;
    logic [7:0] got;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        got  = {sel_src1, sel_src2, hazard_freeze, bubble, pipe_freeze, mem_timeout};
        want = {e.s1, e.s2, e.hf, e.bub, e.pf, e.to};
        if (!e.chk_sel) begin
          got[7:4]  = 4'b0000;
          want[7:4] = 4'b0000;
        end
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got sel1=%0d sel2=%0d hf=%b bub=%b pf=%b to=%b, expected sel1=%0d sel2=%0d hf=%b bub=%b pf=%b to=%b (sel %s)",
                   e.tag, sel_src1, sel_src2, hazard_freeze, bubble, pipe_freeze, mem_timeout,
                   e.s1, e.s2, e.hf, e.bub, e.pf, e.to, e.chk_sel ? "checked" : "ignored");
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_nop();
    id_valid    = 1'b0;
    id_src1     = 4'd0;
    id_src2     = 4'd0;
    id_two_src  = 1'b0;
    id_dst      = 4'd0;
    id_wb_en    = 1'b0;
    id_mem_r_en = 1'b0;
  endtask

  task automatic id_ins(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic [3:0] dst, input logic wb, input logic mr);
    id_valid    = 1'b1;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_dst      = dst;
    id_wb_en    = wb;
    id_mem_r_en = mr;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                            input logic hf, input logic bub, input logic pf,
                            input logic to, input bit chk_sel);
    exp_t e;
    e.tag     = tag;
    e.s1      = s1;
    e.s2      = s2;
    e.hf      = hf;
    e.bub     = bub;
    e.pf      = pf;
    e.to      = to;
    e.chk_sel = chk_sel;
    exp_q.push_back(e);
  endtask

  // Four NOP cycles empty every slot and leave the selects at 0.
  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      tick();
      id_nop();
      branch_taken = 1'b0;
      mem_ready    = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  initial begin
    rst          = 1'b0;
    mem_ready    = 1'b1;
    branch_taken = 1'b0;
    id_nop();

    tick();
    expect_out("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;

    // ADD R1 ; ADD R2,R1,R3 back to back
    tick(); id_ins(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    expect_out("t1_prod", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
`ifdef EXE_FWD_EN
    expect_out("t1_cons", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t1_exe", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    expect_out("t1_stall1", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t1_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t1_go", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t1_exe", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    flush();

    // ADD R1 ; ADD R1 ; consumer of R1 on src1 (src2=R1 but not a real read)
    tick(); id_ins(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    expect_out("t2_p1", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    expect_out("t2_p2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd1, 4'd1, 1'b0, 4'd5, 1'b1, 1'b0);
`ifdef EXE_FWD_EN
    expect_out("t2_cons", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t2_ex_wins", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    expect_out("t2_stall1", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t2_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t2_go", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    flush();

    // ADD R1 ; NOP ; SUB R4,R5,R1
    tick(); id_ins(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    expect_out("t3_prod", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t3_nop", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd5, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
`ifdef EXE_FWD_EN
    expect_out("t3_cons", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t3_exe", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    expect_out("t3_stall", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t3_go", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    flush();

    // LDR R1 ; ADD R2,R1,R1
    tick(); id_ins(4'd2, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
    expect_out("t4_ldr", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
    expect_out("t4_stall", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
`ifdef EXE_FWD_EN
    expect_out("t4_one_bubble", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); id_nop();
    expect_out("t4_exe", 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    expect_out("t4_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t4_go", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    flush();

    // LDR R1 ; dependent ADD R2 flushed by a taken branch in the stall cycle
    tick(); id_ins(4'd2, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
    expect_out("t5_ldr", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0); branch_taken = 1'b1;
    expect_out("t5_branch", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    // The next instruction reads R2; the flushed ADD must not be seen in EX.
    tick(); branch_taken = 1'b0; id_ins(4'd2, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    expect_out("t5_flushed", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t5_no_fwd_r2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    flush();

    // ADD R1 ; consumer in ID while memory stalls for 5 cycles
    tick(); id_ins(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    expect_out("t6_prod", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_ins(4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0); mem_ready = 1'b0;
    expect_out("t6_wait1", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      expect_out("t6_wait", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    tick(); mem_ready = 1'b1;
`ifdef EXE_FWD_EN
    expect_out("t6_resume", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t6_exe", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); mem_ready = 1'b0;
    expect_out("t6_hold1", 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("t6_hold2", 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); mem_ready = 1'b1;
    expect_out("t6_release", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t6_next", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    expect_out("t6_resume", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t6_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t6_go", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    flush();

    // mem_ready low for MEM_TIMEOUT cycles sets the sticky timeout flag
    tick(); mem_ready = 1'b0;
    expect_out("t7_low1", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i < MEM_TIMEOUT; i++) begin
      tick();
    end
    tick();
    expect_out("t7_low_last", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); mem_ready = 1'b1;
    expect_out("t7_set", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_out("t7_sticky", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset during the cycle after a load-use stall
    tick(); id_ins(4'd2, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
    expect_out("t8_ldr", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); id_ins(4'd1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
    expect_out("t8_stall", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    expect_out("t8_after_rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); id_nop();
    expect_out("t8_sel_clear", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
